iter_shift_unit: RTL
====================

// Module: iter_shift_unit
// PURPOSE
//  Multi-cycle MIPS shift execution unit for sll/srl/sra (and optional ror).
//  It shifts an operand by shamt, one bit per clock.
//  - Complements the fixed left-by-2 offset shifter: this unit covers right
//    shifts and variable amounts for the ALU path.
//  - Sits beside the ALU and stalls issue through a valid/ready handshake.
// PARAMETERS
//  WIDTH    32  operand/result width in bits
//  SHAMT_W   5  shift-amount width; must equal $clog2(WIDTH)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  in_valid     in   1        request valid
//  in_ready     out  1        unit can accept a request (1 only in IDLE)
//  in_op        in   2        shift_op_t: 00 SLL, 01 SRL, 10 SRA, 11 ROR
//  in_data      in   WIDTH    operand
//  in_shamt     in   SHAMT_W  shift amount
//  out_valid    out  1        result valid (1 only in DONE)
//  out_ready    in   1        consumer accepts the result
//  out_data     out  WIDTH    shifted result
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE.
//    in_ready=1 after release; out_valid=0, out_data=0, busy=0.
//    Internal accumulator and counter reset to 0.
//  - Reset mid-operation aborts the operation immediately; no result is produced.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_valid&&in_ready latches op, data and shamt into acc/cnt.
//    Next state is SHIFT if shamt!=0, else DONE.
//  - SHIFT: each cycle applies one step to acc and does cnt-=1.
//    Leaves for DONE on the cycle cnt goes 1->0.
//  - Per-step rules:
//      SLL  {acc[W-2:0],1'b0}
//      SRL  {1'b0,acc[W-1:1]}
//      SRA  {acc[W-1],acc[W-1:1]}
//      ROR  {acc[0],acc[W-1:1]}
//  - DONE: out_valid=1 and out_data=acc, both held stable until out_ready.
//    out_valid&&out_ready -> IDLE.
//  - Latency: accept edge to out_valid = shamt+1 cycles (shamt=0 -> 1 cycle).
//    Max is WIDTH cycles.
//  - Single outstanding request; in_ready=0 in SHIFT and DONE.
//    No combinational in->out paths.
//  - out_data is driven only from registered acc; it is 0 in IDLE and SHIFT.
//  - Inputs are sampled only on the accept edge; later changes to in_* are ignored.
// CONFIGURATION
//  ITER_SHIFT_ROTATE_EN defined:
//  - op 11 performs a right rotate by shamt.
//  ITER_SHIFT_ROTATE_EN undefined:
//  - op 11 is treated as a zero shift: IDLE->DONE, out_data=in_data.
//  - No rotate logic is synthesised.
// STRUCTURE
//  - Package shift_pkg holds:
//    - typedef enum logic[1:0] shift_op_t {SLL,SRL,SRA,ROR}
//    - typedef enum logic[1:0] shift_state_t {IDLE,SHIFT,DONE}
//    - localparam DEFAULT_WIDTH=32
//  - One sub-module: shift_step. Combinational single-bit step
//    (op, acc) -> next_acc, reused by the FSM datapath.
// TESTING
//  - Reset: rst_n=0 then 1 -> in_ready=1, out_valid=0, out_data=0, busy=0.
//  - SRA: data=32'h8000_0010, shamt=4 -> out_data=32'hF800_0001,
//    out_valid asserted 5 cycles after accept.
//  - SLL/SRL pair:
//    - SLL 32'h0000_0001 by 31 -> 32'h8000_0000.
//    - SRL 32'h8000_0000 by 31 -> 32'h0000_0001.
//  - Zero shift + backpressure: SRL 32'hDEAD_BEEF, shamt=0, out_ready=0 for 3 cycles.
//    - out_data=32'hDEAD_BEEF is held stable and in_ready stays 0.
//    - Returns to IDLE on the first cycle with out_ready=1.
//  - Abort: SLL shamt=20, rst_n=0 at cycle 7.
//    - Outputs go to reset values asynchronously.
//    - Next request SRL 32'hF0 by 4 -> 32'h0F.
//  - ROR: 32'h0000_0003 by 1.
//    - ITER_SHIFT_ROTATE_EN defined -> 32'h8000_0001.
//    - Undefined -> 32'h0000_0003 after 1 cycle.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative MIPS shift unit.
package shift_pkg;

  // Operation codes, encoded to match the 2-bit in_op port.
  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_op_t;

  // Control states of the unit.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// Single-bit shift step: one iteration of the shift datapath.
// Rotate support is compiled in only when ITER_SHIFT_ROTATE_EN is defined;
// otherwise ROR falls through to "hold", since the control never steps it.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  shift_op_t        op_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] acc_o
);

  // Move the accumulator by exactly one bit position according to op.
  always_comb begin
    acc_o = acc_i;
    case (op_i)
      SLL:     acc_o = {acc_i[WIDTH-2:0], 1'b0};
      SRL:     acc_o = {1'b0, acc_i[WIDTH-1:1]};
      SRA:     acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
`ifdef ITER_SHIFT_ROTATE_EN
      ROR:     acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
`endif
      default: acc_o = acc_i;
    endcase
  end

endmodule : shift_step

// File: rtl/iter_shift_unit.sv
// Iterative shift execution unit (sll/srl/sra, optional ror), one bit per clock.
// Optional feature macro: ITER_SHIFT_ROTATE_EN enables op 11 as a right rotate;
// without it op 11 completes immediately and returns the operand unchanged.
// All outputs come straight from flops, so there is no input-to-output path.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  shift_state_t       state_q, state_d;
  shift_op_t          op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               busy_q, busy_d;

  logic [SHAMT_W-1:0] eff_shamt_s;
  logic [WIDTH-1:0]   step_acc_s;
  shift_op_t          in_op_s;

  assign in_op_s = shift_op_t'(in_op);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .acc_o (step_acc_s)
  );

  // Effective shift count: without rotate support, ROR degenerates to a zero shift.
  always_comb begin
    eff_shamt_s = in_shamt;
`ifndef ITER_SHIFT_ROTATE_EN
    if (in_op_s == ROR) begin
      eff_shamt_s = CNT_ZERO;
    end else begin
      eff_shamt_s = in_shamt;
    end
`endif
  end

  // Next-state, datapath and output computation for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d  = in_op_s;
          acc_d = in_data;
          cnt_d = eff_shamt_s;
          if (eff_shamt_s != CNT_ZERO) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = step_acc_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    if (state_d == DONE) begin
      out_data_d = acc_d;
    end else begin
      out_data_d = {WIDTH{1'b0}};
    end
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= SLL;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= CNT_ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule : iter_shift_unit
